pipelined_dot_mac: RTL and testbench
====================================

// Module: pipelined_dot_mac
// PURPOSE
//  Next-generation MAC: streaming dot-product engine with valid/ready on input and output.
//  Accumulates B*C over a vector framed by first/last flags; emits one result per vector.
//  Signed/unsigned mode per vector, wide accumulator, optional saturation.
//  Sits between operand streamers and the result collector.
// PARAMETERS
//  DATA_WIDTH  8   operand width (B, C)
//  ACC_WIDTH   24  accumulator/result width; must be >= 2*DATA_WIDTH
//  CNT_WIDTH   16  width of per-vector beat counter
//  SAT_EN      1   1: clamp on overflow; 0: wrap modulo 2^ACC_WIDTH
// PORTS
//  clk          in   1           system clock, rising edge
//  rst          in   1           synchronous reset, active-high
//  in_valid     in   1           input beat valid
//  in_ready     out  1           input beat accepted when in_valid & in_ready
//  in_first     in   1           beat opens a new vector (discards any partial sum)
//  in_last      in   1           beat closes the vector; result is emitted
//  signed_mode  in   1           sampled on in_first beats: 1 two's-complement, 0 unsigned
//  b_in         in   DATA_WIDTH  operand B
//  c_in         in   DATA_WIDTH  operand C
//  out_valid    out  1           result valid; held until out_ready
//  out_ready    in   1           consumer accepts result
//  mac_out      out  ACC_WIDTH   dot-product result
//  out_sat      out  1           overflow occurred at any beat of this vector
//  out_count    out  CNT_WIDTH   beats in vector, saturates at all-ones
// BEHAVIOUR
//  Reset (rst=1 at edge): all stage valids 0, accumulator 0, out_valid 0, mac_out 0,
//    out_sat 0, out_count 0, mode reg 0 (unsigned). in_ready=0 while rst=1. Aborts any open vector.
//  in_ready = !rst & !(out_valid & !out_ready) (combinational from out_ready).
//  Stall: when out_valid & !out_ready the whole pipeline holds; no beat lost or duplicated.
//  S1: accepted beat registers b, c, first, last, mode (mode = signed_mode if first, else held).
//  S2: product registered, 2*DATA_WIDTH, sign-extended (signed) or zero-extended to ACC_WIDTH.
//  S3: acc_next = (first ? 0 : acc) + product, computed ACC_WIDTH+1 wide; overflow detected.
//    SAT_EN=1: signed clamps to 2^(ACC_WIDTH-1)-1 / -2^(ACC_WIDTH-1); unsigned clamps to all-ones.
//    SAT_EN=0: wrap. Either way sticky vector overflow flag set; cleared on first.
//    Beat counter: 1 on first, else +1, saturating.
//  On last at S3: mac_out/out_sat/out_count loaded, out_valid=1; acc, flag, count reset to 0.
//  Latency: last beat accepted at edge T -> out_valid=1 after edge T+3. Throughput 1 beat/clk.
//  Bubbles (in_valid=0) propagate; accumulator holds.
//  first&last on same beat: result = single product, out_count=1.
//  first with no prior last: partial sum dropped silently, no output.
//  Non-first beat after a last: accumulates onto 0, mode retained from previous vector.
//  Output transfer and new result in same cycle (out_valid & out_ready & last at S3): new result loads.
//  mac_out/out_sat/out_count stable while out_valid & !out_ready.
// STRUCTURE
//  mac_pkg: sat max/min constant functions of ACC_WIDTH, width check (ACC_WIDTH>=2*DATA_WIDTH).
//  Sub-module mac_sat_add: ACC_WIDTH saturating/wrapping adder, signed/unsigned, overflow out.
//  Top: three stage registers, stall enable, counter, output register.
// TESTING (DATA_WIDTH=8, ACC_WIDTH=20, out_ready=1 unless stated)
//  1 unsigned (3,4),(5,6),(7,8) first..last -> mac_out=98, out_count=3, out_sat=0, 3 clk after last.
//  2 signed (-3,4),(127,-128) -> mac_out=20'hFC074 (-16268), out_sat=0, out_count=2.
//  3 signed (-128,-128) x40 beats: SAT_EN=1 -> 20'h7FFFF, out_sat=1; SAT_EN=0 -> 20'hA0000, out_sat=1.
//  4 out_ready=0, single-beat vectors (2,3),(4,5) -> 6 held stable, in_ready=0; release -> 6 then 20.
//  5 rst pulse after two beats of open vector, then (1,1) first&last -> mac_out=1, out_count=1 only.
//  6 (10,10) first, then (2,2) first&last -> single result 4, out_count=1; 100 never emitted.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared constants and helpers for the streaming dot-product MAC.
package mac_pkg;

    localparam int MAX_ACC_WIDTH = 64;

    // Per-beat framing carried alongside the operands through the pipeline.
    typedef struct packed {
        logic first;
        logic last;
        logic mode;   // 1: two's-complement operands, 0: unsigned
    } beat_ctl_t;

    function automatic logic [MAX_ACC_WIDTH-1:0] sat_max_signed(input int acc_width);
        return (MAX_ACC_WIDTH'(1) << (acc_width - 1)) - MAX_ACC_WIDTH'(1);
    endfunction

    function automatic logic [MAX_ACC_WIDTH-1:0] sat_min_signed(input int acc_width);
        return MAX_ACC_WIDTH'(1) << (acc_width - 1);
    endfunction

    function automatic logic [MAX_ACC_WIDTH-1:0] sat_max_unsigned(input int acc_width);
        return (acc_width >= MAX_ACC_WIDTH) ? '1
                                            : (MAX_ACC_WIDTH'(1) << acc_width) - MAX_ACC_WIDTH'(1);
    endfunction

    function automatic bit acc_width_ok(input int data_width, input int acc_width);
        return (acc_width >= 2 * data_width) && (acc_width <= MAX_ACC_WIDTH);
    endfunction

endpackage

// File: rtl/mac_sat_add.sv
// ACC_WIDTH adder with signed/unsigned overflow detection and optional clamping.
module mac_sat_add
    import mac_pkg::*;
#(
    parameter int ACC_WIDTH = 24,
    parameter int SAT_EN    = 1
) (
    input  logic [ACC_WIDTH-1:0] a,
    input  logic [ACC_WIDTH-1:0] b,
    input  logic                 signed_mode,
    output logic [ACC_WIDTH-1:0] sum,
    output logic                 ovf
);

    localparam logic [ACC_WIDTH-1:0] SMAX = ACC_WIDTH'(sat_max_signed(ACC_WIDTH));
    localparam logic [ACC_WIDTH-1:0] SMIN = ACC_WIDTH'(sat_min_signed(ACC_WIDTH));
    localparam logic [ACC_WIDTH-1:0] UMAX = ACC_WIDTH'(sat_max_unsigned(ACC_WIDTH));

    logic [ACC_WIDTH:0] ext;

    // NOTE: every output of a combinational block is assigned on every path, otherwise a latch is inferred.
    always_comb begin
        if (signed_mode) begin
            ext = {a[ACC_WIDTH-1], a} + {b[ACC_WIDTH-1], b};
            ovf = ext[ACC_WIDTH] ^ ext[ACC_WIDTH-1];
        end else begin
            ext = {1'b0, a} + {1'b0, b};
            ovf = ext[ACC_WIDTH];
        end
        sum = ext[ACC_WIDTH-1:0];
        // The extra top bit of a signed sum is the true sign, so it picks the clamp direction.
        if (SAT_EN != 0 && ovf) begin
            sum = signed_mode ? (ext[ACC_WIDTH] ? SMIN : SMAX) : UMAX;
        end
    end

endmodule

// File: rtl/pipelined_dot_mac.sv
// Streaming dot-product engine: operand register, product register, accumulator
// register and a held output register, all frozen together while a result waits.
module pipelined_dot_mac
    import mac_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 24,
    parameter int CNT_WIDTH  = 16,
    parameter int SAT_EN     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_first,
    input  logic                  in_last,
    input  logic                  signed_mode,
    input  logic [DATA_WIDTH-1:0] b_in,
    input  logic [DATA_WIDTH-1:0] c_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACC_WIDTH-1:0]  mac_out,
    output logic                  out_sat,
    output logic [CNT_WIDTH-1:0]  out_count
);

    if (!acc_width_ok(DATA_WIDTH, ACC_WIDTH)) begin : g_width_check
        $error("pipelined_dot_mac: ACC_WIDTH must be >= 2*DATA_WIDTH and <= 64");
    end

    localparam int PW = 2 * DATA_WIDTH;

    logic stall, advance, accept, load, fresh;

    logic                  s1_valid_q, s1_valid_d;
    logic [DATA_WIDTH-1:0] s1_b_q, s1_b_d, s1_c_q, s1_c_d;
    beat_ctl_t             s1_ctl_q, s1_ctl_d;

    logic                  s2_valid_q, s2_valid_d;
    logic [ACC_WIDTH-1:0]  s2_prod_q, s2_prod_d;
    beat_ctl_t             s2_ctl_q, s2_ctl_d;

    logic                  s3_valid_q, s3_valid_d, s3_last_q, s3_last_d;
    logic [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic                  acc_ovf_q, acc_ovf_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

    logic                  out_valid_q, out_valid_d;
    logic [ACC_WIDTH-1:0]  mac_out_q, mac_out_d;
    logic                  out_sat_q, out_sat_d;
    logic [CNT_WIDTH-1:0]  out_count_q, out_count_d;

    logic signed [PW-1:0]  prod_s;
    logic [PW-1:0]         prod_u;
    logic [ACC_WIDTH-1:0]  prod_ext, acc_base, acc_sum;
    logic [CNT_WIDTH-1:0]  cnt_base, cnt_next;
    logic                  add_ovf;

    assign stall    = out_valid_q && !out_ready;
    assign advance  = !stall;
    assign in_ready = !rst && !stall;
    assign accept   = in_valid && in_ready;
    assign load     = advance && s3_valid_q && s3_last_q;

    assign prod_s   = $signed({{DATA_WIDTH{s1_b_q[DATA_WIDTH-1]}}, s1_b_q})
                    * $signed({{DATA_WIDTH{s1_c_q[DATA_WIDTH-1]}}, s1_c_q});
    assign prod_u   = {{DATA_WIDTH{1'b0}}, s1_b_q} * {{DATA_WIDTH{1'b0}}, s1_c_q};
    assign prod_ext = s1_ctl_q.mode ? ACC_WIDTH'(prod_s) : ACC_WIDTH'(prod_u);

    // A beat starts from zero if it opens a vector or if the previous beat closed one.
    assign fresh    = s2_ctl_q.first || s3_last_q;
    assign acc_base = fresh ? '0 : acc_q;
    assign cnt_base = fresh ? '0 : cnt_q;
    assign cnt_next = (&cnt_base) ? cnt_base : cnt_base + CNT_WIDTH'(1);

    mac_sat_add #(
        .ACC_WIDTH (ACC_WIDTH),
        .SAT_EN    (SAT_EN)
    ) u_sat_add (
        .a           (acc_base),
        .b           (s2_prod_q),
        .signed_mode (s2_ctl_q.mode),
        .sum         (acc_sum),
        .ovf         (add_ovf)
    );

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_b_d      = s1_b_q;
        s1_c_d      = s1_c_q;
        s1_ctl_d    = s1_ctl_q;
        s2_valid_d  = s2_valid_q;
        s2_prod_d   = s2_prod_q;
        s2_ctl_d    = s2_ctl_q;
        s3_valid_d  = s3_valid_q;
        s3_last_d   = s3_last_q;
        acc_d       = acc_q;
        acc_ovf_d   = acc_ovf_q;
        cnt_d       = cnt_q;
        mac_out_d   = mac_out_q;
        out_sat_d   = out_sat_q;
        out_count_d = out_count_q;
        out_valid_d = load || stall;

        if (advance) begin
            s1_valid_d = accept;
            if (accept) begin
                s1_b_d         = b_in;
                s1_c_d         = c_in;
                s1_ctl_d.first = in_first;
                s1_ctl_d.last  = in_last;
                s1_ctl_d.mode  = in_first ? signed_mode : s1_ctl_q.mode;
            end

            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_prod_d = prod_ext;
                s2_ctl_d  = s1_ctl_q;
            end

            s3_valid_d = s2_valid_q;
            if (s2_valid_q) begin
                acc_d     = acc_sum;
                acc_ovf_d = (!fresh && acc_ovf_q) || add_ovf;
                cnt_d     = cnt_next;
                s3_last_d = s2_ctl_q.last;
            end

            if (load) begin
                mac_out_d   = acc_q;
                out_sat_d   = acc_ovf_q;
                out_count_d = cnt_q;
            end
        end
    end

    // NOTE: sequential state is updated only with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_b_q      <= '0;
            s1_c_q      <= '0;
            s1_ctl_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_prod_q   <= '0;
            s2_ctl_q    <= '0;
            s3_valid_q  <= 1'b0;
            s3_last_q   <= 1'b0;
            acc_q       <= '0;
            acc_ovf_q   <= 1'b0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            mac_out_q   <= '0;
            out_sat_q   <= 1'b0;
            out_count_q <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_b_q      <= s1_b_d;
            s1_c_q      <= s1_c_d;
            s1_ctl_q    <= s1_ctl_d;
            s2_valid_q  <= s2_valid_d;
            s2_prod_q   <= s2_prod_d;
            s2_ctl_q    <= s2_ctl_d;
            s3_valid_q  <= s3_valid_d;
            s3_last_q   <= s3_last_d;
            acc_q       <= acc_d;
            acc_ovf_q   <= acc_ovf_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            mac_out_q   <= mac_out_d;
            out_sat_q   <= out_sat_d;
            out_count_q <= out_count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign mac_out   = mac_out_q;
    assign out_sat   = out_sat_q;
    assign out_count = out_count_q;

endmodule

// File: tb/tb_pipelined_dot_mac.sv
// Bench for pipelined_dot_mac: a saturating and a wrapping instance share one input stream
// and are scored against an arithmetic model of the dot product.
module tb_pipelined_dot_mac;

    localparam int     DW   = 8;
    localparam int     AW   = 20;
    localparam int     CW   = 16;
    localparam longint SMAX = 524287;
    localparam longint SMIN = -524288;
    localparam longint UMAX = 1048575;
    localparam longint MODV = 1048576;
    localparam int     CMAX = 65535;

    logic          clk = 1'b0;
    logic          rst, in_valid, in_first, in_last, signed_mode, out_ready;
    logic [DW-1:0] b_in, c_in;
    logic          in_ready_s, in_ready_w, out_valid_s, out_valid_w, out_sat_s, out_sat_w;
    logic [AW-1:0] mac_out_s, mac_out_w;
    logic [CW-1:0] out_count_s, out_count_w;

    always #5 clk = ~clk;

    pipelined_dot_mac #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .CNT_WIDTH(CW), .SAT_EN(1)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s), .in_first(in_first),
        .in_last(in_last), .signed_mode(signed_mode), .b_in(b_in), .c_in(c_in),
        .out_valid(out_valid_s), .out_ready(out_ready), .mac_out(mac_out_s),
        .out_sat(out_sat_s), .out_count(out_count_s));

    pipelined_dot_mac #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .CNT_WIDTH(CW), .SAT_EN(0)) dut_wrap (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w), .in_first(in_first),
        .in_last(in_last), .signed_mode(signed_mode), .b_in(b_in), .c_in(c_in),
        .out_valid(out_valid_w), .out_ready(out_ready), .mac_out(mac_out_w),
        .out_sat(out_sat_w), .out_count(out_count_w));

    typedef struct {
        logic [AW-1:0] mac_s;
        logic [AW-1:0] mac_w;
        logic          sat_s;
        logic          sat_w;
        logic [CW-1:0] cnt;
    } result_t;

    result_t exp_q[$];
    result_t exp_r;
    longint  m_acc_s, m_acc_w;
    bit      m_flag_s, m_flag_w, m_mode;
    int      m_cnt;
    int      checks = 0;
    int      errors = 0;
    int      results_seen = 0;
    logic [AW-1:0] got_mac_s, got_mac_w;
    logic          got_sat_s, got_sat_w;
    logic [CW-1:0] got_cnt;
    bit      rand_done;

    function automatic void model_clear_vector();
        m_acc_s = 0; m_acc_w = 0; m_flag_s = 0; m_flag_w = 0; m_cnt = 0;
    endfunction

    function automatic void model_reset();
        model_clear_vector();
        m_mode = 0;
        exp_q.delete();
    endfunction

    // Dot-product rules in plain integer arithmetic: exact sum, then clamp or wrap into range.
    function automatic void model_beat(bit first, bit last, bit mode, logic [DW-1:0] b, logic [DW-1:0] c);
        longint vb, vc, lo, hi, t;
        result_t r;
        if (first) begin
            model_clear_vector();
            m_mode = mode;
        end
        vb = longint'(b);
        vc = longint'(c);
        if (m_mode && b[DW-1]) vb -= 256;
        if (m_mode && c[DW-1]) vc -= 256;
        lo = m_mode ? SMIN : 0;
        hi = m_mode ? SMAX : UMAX;
        m_acc_s += vb * vc;
        m_acc_w += vb * vc;
        if (m_acc_s > hi) begin m_acc_s = hi; m_flag_s = 1; end
        else if (m_acc_s < lo) begin m_acc_s = lo; m_flag_s = 1; end
        if (m_acc_w > hi || m_acc_w < lo) begin
            m_flag_w = 1;
            t = (m_acc_w - lo) % MODV;
            if (t < 0) t += MODV;
            m_acc_w = lo + t;
        end
        m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
        if (last) begin
            r.mac_s = m_acc_s[AW-1:0];
            r.mac_w = m_acc_w[AW-1:0];
            r.sat_s = m_flag_s;
            r.sat_w = m_flag_w;
            r.cnt   = CW'(m_cnt);
            exp_q.push_back(r);
            model_clear_vector();
        end
    endfunction

    // Scoreboard: every transferred result is compared with the next model result.
    always @(negedge clk) begin
        #1;
        if (!rst && out_ready && (out_valid_s || out_valid_w)) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_result: got mac_out=%h, required no pending result", mac_out_s);
            end else begin
                exp_r = exp_q.pop_front();
                checks++;
                if ({out_valid_s, mac_out_s, out_sat_s, out_count_s} !== {1'b1, exp_r.mac_s, exp_r.sat_s, exp_r.cnt}) begin
                    errors++;
                    $display("FAIL result_sat: got v=%b mac=%h sat=%b cnt=%0d, required v=1 mac=%h sat=%b cnt=%0d",
                             out_valid_s, mac_out_s, out_sat_s, out_count_s, exp_r.mac_s, exp_r.sat_s, exp_r.cnt);
                end
                checks++;
                if ({out_valid_w, mac_out_w, out_sat_w, out_count_w} !== {1'b1, exp_r.mac_w, exp_r.sat_w, exp_r.cnt}) begin
                    errors++;
                    $display("FAIL result_wrap: got v=%b mac=%h sat=%b cnt=%0d, required v=1 mac=%h sat=%b cnt=%0d",
                             out_valid_w, mac_out_w, out_sat_w, out_count_w, exp_r.mac_w, exp_r.sat_w, exp_r.cnt);
                end
                got_mac_s = mac_out_s; got_mac_w = mac_out_w;
                got_sat_s = out_sat_s; got_sat_w = out_sat_w;
                got_cnt   = out_count_s;
                results_seen++;
            end
        end
    end

    task automatic send_beat(input bit first, input bit last, input bit mode,
                             input logic [DW-1:0] b, input logic [DW-1:0] c);
        int guard = 0;
        @(negedge clk);
        in_valid = 1'b1; in_first = first; in_last = last; signed_mode = mode;
        b_in = b; c_in = c;
        #1;
        while (!(in_ready_s && in_ready_w)) begin
            @(negedge clk); #1;
            guard++;
            if (guard > 500) begin
                checks++; errors++;
                $display("FAIL send_timeout: in_ready=%b, required 1", in_ready_s);
                in_valid = 1'b0;
                return;
            end
        end
        model_beat(first, last, mode, b, c);
        @(posedge clk);
    endtask

    task automatic bubble();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int guard = 0;
        bubble();
        while ((exp_q.size() != 0 || out_valid_s || out_valid_w) && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (exp_q.size() != 0 || out_valid_s !== 1'b0) begin
            errors++;
            $display("FAIL drain_timeout: %0d results pending, out_valid=%b, required 0 and 0", exp_q.size(), out_valid_s);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0;
        #1;
        checks++;
        if (in_ready_s !== 1'b0) begin
            errors++; $display("FAIL ready_in_reset: in_ready=%b, required 0", in_ready_s);
        end
        @(negedge clk); #1;
        checks++;
        if ({out_valid_s, mac_out_s, out_sat_s, out_count_s} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: v=%b mac=%h sat=%b cnt=%0d, required all 0",
                     out_valid_s, mac_out_s, out_sat_s, out_count_s);
        end
        model_reset();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
    endtask

    task automatic test_unsigned_latency();
        send_beat(1, 0, 0, 8'd3, 8'd4);
        send_beat(0, 0, 0, 8'd5, 8'd6);
        send_beat(0, 1, 0, 8'd7, 8'd8);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) in_valid = 1'b0;
            #2;
            checks++;
            if (out_valid_s !== (i == 3)) begin
                errors++;
                $display("FAIL latency_%0d: out_valid=%b, required %b", i, out_valid_s, (i == 3));
            end
        end
        wait_drain();
        checks++;
        if ({got_mac_s, got_sat_s, got_cnt} !== {20'd98, 1'b0, 16'd3}) begin
            errors++;
            $display("FAIL unsigned_basic: mac=%0d sat=%b cnt=%0d, required 98 0 3", got_mac_s, got_sat_s, got_cnt);
        end
    endtask

    task automatic test_signed();
        send_beat(1, 0, 1, 8'hFD, 8'h04);
        send_beat(0, 1, 1, 8'h7F, 8'h80);
        wait_drain();
        checks++;
        if ({got_mac_s, got_sat_s, got_cnt} !== {20'hFC074, 1'b0, 16'd2}) begin
            errors++;
            $display("FAIL signed_basic: mac=%h sat=%b cnt=%0d, required fc074 0 2", got_mac_s, got_sat_s, got_cnt);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 40; i++) send_beat(i == 0, i == 39, 1, 8'h80, 8'h80);
        wait_drain();
        checks++;
        if ({got_mac_s, got_sat_s, got_mac_w, got_sat_w, got_cnt} !== {20'h7FFFF, 1'b1, 20'hA0000, 1'b1, 16'd40}) begin
            errors++;
            $display("FAIL signed_overflow: sat=%h/%b wrap=%h/%b cnt=%0d, required 7ffff/1 a0000/1 40",
                     got_mac_s, got_sat_s, got_mac_w, got_sat_w, got_cnt);
        end
        for (int i = 0; i < 20; i++) send_beat(i == 0, i == 19, 0, 8'hFF, 8'hFF);
        wait_drain();
        checks++;
        if ({got_mac_s, got_sat_s, got_mac_w, got_sat_w} !== {20'hFFFFF, 1'b1, 20'h3D814, 1'b1}) begin
            errors++;
            $display("FAIL unsigned_overflow: sat=%h/%b wrap=%h/%b, required fffff/1 3d814/1",
                     got_mac_s, got_sat_s, got_mac_w, got_sat_w);
        end
    endtask

    task automatic test_stall();
        int guard = 0;
        int seen0 = results_seen;
        @(negedge clk);
        out_ready = 1'b0;
        send_beat(1, 1, 0, 8'd2, 8'd3);
        send_beat(1, 1, 0, 8'd4, 8'd5);
        bubble();
        while (!out_valid_s && guard < 20) begin @(negedge clk); guard++; end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #2;
            checks++;
            if ({out_valid_s, mac_out_s, out_count_s, in_ready_s} !== {1'b1, 20'd6, 16'd1, 1'b0}) begin
                errors++;
                $display("FAIL stall_hold_%0d: v=%b mac=%0d cnt=%0d in_ready=%b, required 1 6 1 0",
                         i, out_valid_s, mac_out_s, out_count_s, in_ready_s);
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        wait_drain();
        checks++;
        if (results_seen - seen0 != 2 || got_mac_s !== 20'd20) begin
            errors++;
            $display("FAIL stall_release: %0d results, last mac=%0d, required 2 results ending in 20",
                     results_seen - seen0, got_mac_s);
        end
    endtask

    task automatic test_reset_abort();
        int seen0;
        send_beat(1, 0, 0, 8'd5, 8'd5);
        send_beat(0, 0, 0, 8'd6, 8'd6);
        apply_reset();
        seen0 = results_seen;
        send_beat(1, 1, 0, 8'd1, 8'd1);
        wait_drain();
        checks++;
        if (results_seen - seen0 != 1 || {got_mac_s, got_cnt} !== {20'd1, 16'd1}) begin
            errors++;
            $display("FAIL reset_abort: %0d results, mac=%0d cnt=%0d, required 1 result 1 1",
                     results_seen - seen0, got_mac_s, got_cnt);
        end
    endtask

    task automatic test_first_restart();
        int seen0 = results_seen;
        send_beat(1, 0, 0, 8'd10, 8'd10);
        send_beat(1, 1, 0, 8'd2, 8'd2);
        wait_drain();
        checks++;
        if (results_seen - seen0 != 1 || {got_mac_s, got_cnt} !== {20'd4, 16'd1}) begin
            errors++;
            $display("FAIL first_restart: %0d results, mac=%0d cnt=%0d, required 1 result 4 1",
                     results_seen - seen0, got_mac_s, got_cnt);
        end
    endtask

    task automatic test_back_to_back();
        send_beat(1, 0, 1, 8'hFF, 8'h01);
        send_beat(0, 1, 1, 8'hFF, 8'h01);
        send_beat(0, 1, 0, 8'hFF, 8'h02);
        wait_drain();
        checks++;
        if ({got_mac_s, got_cnt} !== {20'hFFFFE, 16'd1}) begin
            errors++;
            $display("FAIL mode_retained: mac=%h cnt=%0d, required ffffe 1", got_mac_s, got_cnt);
        end
    endtask

    task automatic test_random();
        rand_done = 0;
        fork
            while (!rand_done) begin
                @(negedge clk);
                out_ready = ($urandom_range(0, 9) < 7);
            end
            begin
                for (int v = 0; v < 60; v++) begin
                    int  len   = $urandom_range(1, 6);
                    bit  mode  = $urandom_range(0, 1);
                    bit  nofst = ($urandom_range(0, 9) == 0);
                    bit  abort = ($urandom_range(0, 9) == 0);
                    for (int i = 0; i < len; i++) begin
                        send_beat(i == 0 && !nofst, i == len - 1 && !abort, mode,
                                  DW'($urandom), DW'($urandom));
                        if ($urandom_range(0, 99) < 15) bubble();
                    end
                end
                rand_done = 1;
            end
        join
        @(negedge clk);
        out_ready = 1'b1;
        wait_drain();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
        signed_mode = 1'b0; b_in = '0; c_in = '0; out_ready = 1'b1;
        model_reset();
        test_reset();
        test_unsigned_latency();
        test_signed();
        test_saturation();
        test_stall();
        test_reset_abort();
        test_first_restart();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
